// File: rtl/elevator_pkg.sv
// Shared types, floor codes and request-scan helpers for the elevator controller.
package elevator_pkg;

  localparam int MAX_FLOORS = 4;

  typedef logic [1:0] floor_t;
  typedef logic [MAX_FLOORS-1:0] req_vec_t;

  typedef enum logic [1:0] {
    IDLE,
    MOVE_UP,
    MOVE_DOWN,
    DOOR_OPEN
  } state_e;

  typedef enum logic {
    UP,
    DOWN
  } dir_e;

  localparam floor_t FLOOR_1 = 2'b00;
  localparam floor_t FLOOR_2 = 2'b01;
  localparam floor_t FLOOR_3 = 2'b10;

  // Requests are zero-extended to MAX_FLOORS so one helper serves every build size.
  function automatic logic req_above(req_vec_t req, floor_t floor);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if (req[i] && (i > int'(floor))) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic req_below(req_vec_t req, floor_t floor);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if (req[i] && (i < int'(floor))) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/elevator_ctrl_if.sv
// Request/status bundle between the elevator controller and its surroundings.
// The obstruction sensor only exists when ELEV_OBSTRUCTION_EN is defined.
interface elevator_ctrl_if
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 3
) ();
  logic [NUM_FLOORS-1:0] call_btn;
`ifdef ELEV_OBSTRUCTION_EN
  logic                  obstruction;
`endif
  floor_t                floor_idx;
  logic [NUM_FLOORS-1:0] pending;
  logic                  motor_up;
  logic                  motor_down;
  logic                  door_open;
  logic                  busy;

`ifdef ELEV_OBSTRUCTION_EN
  modport master (
    output call_btn, obstruction,
    input  floor_idx, pending, motor_up, motor_down, door_open, busy
  );
  modport slave (
    input  call_btn, obstruction,
    output floor_idx, pending, motor_up, motor_down, door_open, busy
  );
`else
  modport master (
    output call_btn,
    input  floor_idx, pending, motor_up, motor_down, door_open, busy
  );
  modport slave (
    input  call_btn,
    output floor_idx, pending, motor_up, motor_down, door_open, busy
  );
`endif

endinterface

// File: rtl/elev_timer.sv
// Phase timer shared by travel and door dwell: counts 0..last, wraps to 0 after last.
// clr forces zero, en low holds the count, tc flags the final count of the phase.
module elev_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] last,
  output logic             tc
);
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign tc = (count_q == last);

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = tc ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/elevator_ctrl.sv
// SCAN-scheduled elevator controller: latches calls, picks direction, times travel and door dwell.
// Define ELEV_OBSTRUCTION_EN to add an obstruction input that holds the door open.
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = 3,
  parameter int TRAVEL_CYCLES = 50_000_000,
  parameter int DOOR_CYCLES   = 100_000_000
) (
  input  logic           clk,
  input  logic           rst_n,
  elevator_ctrl_if.slave bus
);
  localparam int TMR_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX);
  localparam logic [TMR_W-1:0] TRAVEL_LAST = TMR_W'(TRAVEL_CYCLES - 1);
  localparam logic [TMR_W-1:0] DOOR_LAST   = TMR_W'(DOOR_CYCLES - 1);
  localparam floor_t TOP_FLOOR = floor_t'(NUM_FLOORS - 1);

  state_e                state_q, state_d;
  dir_e                  dir_q, dir_d;
  floor_t                floor_q, floor_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [NUM_FLOORS-1:0] call_q, call_d;
  logic                  motor_up_q, motor_up_d;
  logic                  motor_down_q, motor_down_d;
  logic                  door_open_q, door_open_d;
  logic                  busy_q, busy_d;

  req_vec_t              call_ext, callq_ext, pend_ext;
  logic [NUM_FLOORS-1:0] set_mask, clr_mask;
  logic                  door_hold;
  logic                  tmr_clr, tmr_en, tmr_tc;
  logic [TMR_W-1:0]      tmr_last;

  always_comb begin
    call_ext  = '0;
    callq_ext = '0;
    pend_ext  = '0;
    call_ext[NUM_FLOORS-1:0]  = bus.call_btn;
    callq_ext[NUM_FLOORS-1:0] = call_q;
    pend_ext[NUM_FLOORS-1:0]  = pending_q;
  end

`ifdef ELEV_OBSTRUCTION_EN
  assign door_hold = call_ext[floor_q] | bus.obstruction;
`else
  assign door_hold = call_ext[floor_q];
`endif

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    floor_d  = floor_q;
    call_d   = bus.call_btn;
    clr_mask = '0;
    set_mask = bus.call_btn;
    tmr_clr  = 1'b0;
    tmr_en   = (state_q != IDLE);
    tmr_last = (state_q == DOOR_OPEN) ? DOOR_LAST : TRAVEL_LAST;

    // A call at the floor the cabin is standing at is served by the door, not latched.
    if ((state_q == IDLE) || (state_q == DOOR_OPEN)) begin
      set_mask[floor_q] = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        tmr_clr = 1'b1;
        if (callq_ext[floor_q] || pend_ext[floor_q]) begin
          state_d           = DOOR_OPEN;
          clr_mask[floor_q] = 1'b1;
        end else if (req_above(pend_ext, floor_q) && req_below(pend_ext, floor_q)) begin
          state_d = (dir_q == UP) ? MOVE_UP : MOVE_DOWN;
        end else if (req_above(pend_ext, floor_q)) begin
          state_d = MOVE_UP;
          dir_d   = UP;
        end else if (req_below(pend_ext, floor_q)) begin
          state_d = MOVE_DOWN;
          dir_d   = DOWN;
        end
      end

      MOVE_UP: begin
        if (tmr_tc) begin
          if (floor_q < TOP_FLOOR) begin
            floor_d = floor_q + 2'd1;
            if (pend_ext[floor_d]) begin
              state_d           = DOOR_OPEN;
              clr_mask[floor_d] = 1'b1;
            end else if (!req_above(pend_ext, floor_d)) begin
              state_d = IDLE;
            end
          end else begin
            state_d = IDLE;
          end
        end
      end

      MOVE_DOWN: begin
        if (tmr_tc) begin
          if (floor_q != FLOOR_1) begin
            floor_d = floor_q - 2'd1;
            if (pend_ext[floor_d]) begin
              state_d           = DOOR_OPEN;
              clr_mask[floor_d] = 1'b1;
            end else if (!req_below(pend_ext, floor_d)) begin
              state_d = IDLE;
            end
          end else begin
            state_d = IDLE;
          end
        end
      end

      DOOR_OPEN: begin
        if (door_hold) begin
          tmr_clr = 1'b1;
        end else if (tmr_tc) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    pending_d    = (pending_q | set_mask) & ~clr_mask;
    motor_up_d   = (state_d == MOVE_UP);
    motor_down_d = (state_d == MOVE_DOWN);
    door_open_d  = (state_d == DOOR_OPEN);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      dir_q        <= UP;
      floor_q      <= FLOOR_1;
      pending_q    <= '0;
      call_q       <= '0;
      motor_up_q   <= 1'b0;
      motor_down_q <= 1'b0;
      door_open_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      floor_q      <= floor_d;
      pending_q    <= pending_d;
      call_q       <= call_d;
      motor_up_q   <= motor_up_d;
      motor_down_q <= motor_down_d;
      door_open_q  <= door_open_d;
      busy_q       <= busy_d;
    end
  end

  elev_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .last  (tmr_last),
    .tc    (tmr_tc)
  );

  assign bus.floor_idx  = floor_q;
  assign bus.pending    = pending_q;
  assign bus.motor_up   = motor_up_q;
  assign bus.motor_down = motor_down_q;
  assign bus.door_open  = door_open_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl with a cycle model built from countdowns and request arrays.
// Define ELEV_OBSTRUCTION_EN to also exercise the obstruction hold.
module tb_elevator_ctrl;
  localparam int NF     = 3;
  localparam int TRAVEL = 4;
  localparam int DOOR   = 3;

  localparam int M_IDLE = 0;
  localparam int M_UP   = 1;
  localparam int M_DOWN = 2;
  localparam int M_DOOR = 3;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  elevator_ctrl_if #(.NUM_FLOORS(NF)) bus ();

  elevator_ctrl #(
    .NUM_FLOORS    (NF),
    .TRAVEL_CYCLES (TRAVEL),
    .DOOR_CYCLES   (DOOR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: mode, cycles left in the current phase, requests seen last cycle.
  int       m_mode;
  int       m_floor;
  int       m_left;
  bit       m_dir_up;
  bit [2:0] m_pend;
  bit [2:0] m_seen;
  bit       m_obs;

`ifdef ELEV_OBSTRUCTION_EN
  assign m_obs = bus.obstruction;
`else
  assign m_obs = 1'b0;
`endif

  function automatic bit any_req(input bit [2:0] r, input int lo, input int hi);
    bit hit = 1'b0;
    for (int i = lo; i <= hi; i++) begin
      if (i >= 0 && i < NF && r[i]) hit = 1'b1;
    end
    return hit;
  endfunction

  task automatic model_step();
    bit [2:0] req;
    bit [2:0] btn;
    bit [2:0] fresh;
    bit       standing;
    bit       up;
    bit       dn;
    int       served;
    req      = m_pend;
    btn      = bus.call_btn;
    fresh    = '0;
    served   = -1;
    standing = (m_mode == M_IDLE) || (m_mode == M_DOOR);
    for (int i = 0; i < NF; i++) begin
      if (btn[i] && !(standing && i == m_floor)) fresh[i] = 1'b1;
    end
    case (m_mode)
      M_IDLE: begin
        up = any_req(req, m_floor + 1, NF - 1);
        dn = any_req(req, 0, m_floor - 1);
        if (m_seen[m_floor] || req[m_floor]) begin
          m_mode = M_DOOR; m_left = DOOR; served = m_floor;
        end else if (up && (!dn || m_dir_up)) begin
          m_mode = M_UP; m_dir_up = 1'b1; m_left = TRAVEL;
        end else if (dn) begin
          m_mode = M_DOWN; m_dir_up = 1'b0; m_left = TRAVEL;
        end
      end
      M_UP, M_DOWN: begin
        m_left--;
        if (m_left == 0) begin
          m_floor = (m_mode == M_UP) ? m_floor + 1 : m_floor - 1;
          if (req[m_floor]) begin
            m_mode = M_DOOR; m_left = DOOR; served = m_floor;
          end else if ((m_mode == M_UP) ? any_req(req, m_floor + 1, NF - 1)
                                        : any_req(req, 0, m_floor - 1)) begin
            m_left = TRAVEL;
          end else begin
            m_mode = M_IDLE;
          end
        end
      end
      default: begin
        if (btn[m_floor] || m_obs) begin
          m_left = DOOR;
        end else begin
          m_left--;
          if (m_left == 0) m_mode = M_IDLE;
        end
      end
    endcase
    m_pend = req | fresh;
    if (served >= 0) m_pend[served] = 1'b0;
    m_seen = btn;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_IDLE; m_floor = 0; m_left = 0; m_dir_up = 1'b1; m_pend = '0; m_seen = '0;
    end else begin
      model_step();
    end
  end

  // Every cycle: the full output set must match the model.
  always @(negedge clk) begin
    logic [1:0] e_floor;
    logic [2:0] e_pend;
    logic       e_up, e_dn, e_door, e_busy;
    e_floor = 2'(m_floor);
    e_pend  = m_pend;
    e_up    = (m_mode == M_UP);
    e_dn    = (m_mode == M_DOWN);
    e_door  = (m_mode == M_DOOR);
    e_busy  = (m_mode != M_IDLE);
    vectors++;
    if (bus.floor_idx !== e_floor || bus.pending !== e_pend || bus.motor_up !== e_up ||
        bus.motor_down !== e_dn || bus.door_open !== e_door || bus.busy !== e_busy ||
        (bus.motor_up && bus.motor_down)) begin
      miscompares++;
      $display("FAIL cycle@%0t: floor %0d/%0d pend %b/%b up %b/%b dn %b/%b door %b/%b busy %b/%b (got/required)",
               $time, bus.floor_idx, e_floor, bus.pending, e_pend, bus.motor_up, e_up,
               bus.motor_down, e_dn, bus.door_open, e_door, bus.busy, e_busy);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic press(input logic [2:0] v);
    bus.call_btn = v;
    tick();
    bus.call_btn = '0;
  endtask

  task automatic until_floor(input int f, output int n);
    n = 0;
    while (int'(bus.floor_idx) != f && n < 40) begin
      tick();
      n++;
    end
    if (int'(bus.floor_idx) != f) check("floor_timeout", int'(bus.floor_idx), f);
  endtask

  task automatic until_door();
    int n = 0;
    while (!bus.door_open && n < 40) begin
      tick();
      n++;
    end
    check("door_wait", int'(bus.door_open), 1);
  endtask

  task automatic count_door(output int n);
    n = 0;
    while (bus.door_open && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus.busy || bus.pending != '0) && n < 300) begin
      tick();
      n++;
    end
    check("settle", int'({bus.busy, bus.pending}), 0);
  endtask

  initial begin
    int n;
    int m;
    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b0;
    bus.call_btn = '0;
`ifdef ELEV_OBSTRUCTION_EN
    bus.obstruction = 1'b0;
`endif
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_floor", int'(bus.floor_idx), 0);
    check("rst_pending", int'(bus.pending), 0);
    check("rst_outputs", int'({bus.motor_up, bus.motor_down, bus.door_open, bus.busy}), 0);

    // Floor 0 -> floor 2 on a single top-floor call
    press(3'b100);
    check("t1_pending", int'(bus.pending), 4);
    check("t1_still_idle", int'(bus.busy), 0);
    tick();
    check("t1_motor_up", int'(bus.motor_up), 1);
    until_floor(1, n);
    check("t1_travel_0_1", n, TRAVEL);
    until_floor(2, n);
    check("t1_travel_1_2", n, TRAVEL);
    check("t1_door_at_2", int'(bus.door_open), 1);
    check("t1_pending_clr", int'(bus.pending), 0);
    count_door(n);
    check("t1_door_len", n, DOOR);
    check("t1_idle", int'(bus.busy), 0);

    // Floor 2 down to 0 with an intermediate stop at floor 1
    press(3'b001);
    tick();
    check("t3_motor_down", int'(bus.motor_down), 1);
    press(3'b010);
    until_floor(1, n);
    check("t3_door_at_1", int'(bus.door_open), 1);
    check("t3_pending_left", int'(bus.pending), 1);
    count_door(n);
    check("t3_door_len", n, DOOR);
    check("t3_idle_gap", int'({bus.busy, bus.motor_down}), 0);
    tick();
    check("t3_resume_down", int'(bus.motor_down), 1);
    until_floor(0, n);
    check("t3_travel_1_0", n, TRAVEL);
    check("t3_door_at_0", int'(bus.door_open), 1);
    wait_idle();

    // Call at the idle floor opens the door two edges later
    press(3'b001);
    check("t2_door_not_yet", int'(bus.door_open), 0);
    check("t2_pending_zero", int'(bus.pending), 0);
    tick();
    check("t2_door_open", int'(bus.door_open), 1);
    check("t2_motors", int'({bus.motor_up, bus.motor_down}), 0);
    check("t2_pending_still0", int'(bus.pending), 0);
    wait_idle();

    // At floor 1 heading up, requests both sides: up first, then down
    press(3'b010);
    wait_idle();
    check("t4_at_1", int'(bus.floor_idx), 1);
    press(3'b101);
    check("t4_pending", int'(bus.pending), 5);
    tick();
    check("t4_goes_up", int'(bus.motor_up), 1);
    until_floor(2, n);
    check("t4_door_at_2", int'(bus.door_open), 1);
    check("t4_pending_0", int'(bus.pending), 1);
    wait_idle();
    check("t4_end_floor0", int'(bus.floor_idx), 0);

    // Door restart: call at floor 1 in the second door cycle
    press(3'b010);
    until_door();
    tick();
    bus.call_btn = 3'b010;
    tick();
    bus.call_btn = '0;
    count_door(n);
    check("t5_door_total", 2 + n, 2 + DOOR);
    check("t5_pending_0", int'(bus.pending), 0);
    wait_idle();

    // Asynchronous reset while travelling from floor 1 to 2
    press(3'b100);
    tick();
    check("t6_moving", int'(bus.motor_up), 1);
    tick();
    rst_n = 1'b0;
    #1;
    check("t6_floor", int'(bus.floor_idx), 0);
    check("t6_pending", int'(bus.pending), 0);
    check("t6_outputs", int'({bus.motor_up, bus.motor_down, bus.door_open, bus.busy}), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

`ifdef ELEV_OBSTRUCTION_EN
    // Obstruction held for 10 cycles stretches the dwell to 10 + DOOR
    press(3'b001);
    tick();
    check("t7_door_open", int'(bus.door_open), 1);
    bus.obstruction = 1'b1;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      n += int'(bus.door_open);
      tick();
    end
    bus.obstruction = 1'b0;
    count_door(m);
    check("t7_door_total", n + m, 10 + DOOR);
    wait_idle();
`else
    m = 0;
    check("t7_no_obstruction_idle", int'(bus.busy) + m, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
